// File: rtl/cave_game_ctrl.sv
// cave_game_ctrl: game sequencer for the cave display.
// Owns the scroll tick, the IDLE/RUN/OVER state machine, seed capture, the BCD
// score and high score, and the button synchronizer and debouncer.
// Optional feature macro: CAVE_HISCORE_EN builds the high-score register and
// its comparator. When the macro is undefined, hscore is tied to zero.
module cave_game_ctrl #(
    parameter int TICK_DIV   = 1048576,
    parameter int DB_CYCLES  = 16,
    parameter int HOLD_TICKS = 48
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn,
    input  logic        crash,
    output logic        tick,
    output logic        enable,
    output logic        seed_load,
    output logic [15:0] seed,
    output logic        btn_held,
    output logic [15:0] score,
    output logic [15:0] hscore,
    output logic [1:0]  state
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DB_CYCLES + 1);
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [TW-1:0] TICK_PRE  = TW'(TICK_DIV - 2);
    localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_OVER = 2'b10
    } state_t;

    state_t        state_q;
    logic          btn_s1_q, btn_s2_q;
    logic [DW-1:0] db_cnt_q;
    logic          btn_held_q, held_dly_q;
    logic [TW-1:0] tick_cnt_q;
    logic          tick_q;
    logic [15:0]   fcnt_q;
    logic [HW-1:0] hold_cnt_q;
    logic [HW-1:0] hold_cnt_d;
    logic          enable_q, seed_load_q;
    logic [15:0]   seed_q, score_q;
    logic          press;

    // Saturating 4-digit BCD increment; 9999 stays 9999.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        if (v == 16'h9999) return v;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign press      = btn_held_q & ~held_dly_q;
    assign hold_cnt_d = hold_cnt_q + HW'(1);

    // Two-flop synchronizer followed by a consecutive-sample debouncer.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_s1_q   <= 1'b0;
            btn_s2_q   <= 1'b0;
            db_cnt_q   <= '0;
            btn_held_q <= 1'b0;
            held_dly_q <= 1'b0;
        end else begin
            btn_s1_q   <= btn;
            btn_s2_q   <= btn_s1_q;
            held_dly_q <= btn_held_q;
            if (btn_s2_q != btn_held_q) begin
                if (db_cnt_q == DB_LAST) begin
                    btn_held_q <= ~btn_held_q;
                    db_cnt_q   <= '0;
                end else begin
                    db_cnt_q <= db_cnt_q + DW'(1);
                end
            end else begin
                db_cnt_q <= '0;
            end
        end
    end

    // Free-running scroll tick (registered, high while the count is at its top) and seed counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt_q <= '0;
            tick_q     <= 1'b0;
            fcnt_q     <= '0;
        end else begin
            tick_cnt_q <= (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + TW'(1);
            tick_q     <= (tick_cnt_q == TICK_PRE);
            fcnt_q     <= fcnt_q + 16'd1;
        end
    end

`ifdef CAVE_HISCORE_EN
    logic [15:0] hscore_q;

    // High score captured on the RUN->OVER transition when strictly beaten.
    always_ff @(posedge clk) begin
        if (reset) begin
            hscore_q <= '0;
        end else if (state_q == S_RUN && tick_q && crash && (score_q > hscore_q)) begin
            hscore_q <= score_q;
        end
    end

    assign hscore = hscore_q;
`else
    assign hscore = 16'h0000;
`endif

    // Game state machine with registered enable, seed, seed_load and score.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            enable_q    <= 1'b0;
            seed_load_q <= 1'b0;
            seed_q      <= '0;
            score_q     <= '0;
            hold_cnt_q  <= '0;
        end else begin
            seed_load_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // A start takes priority over a coincident tick.
                    if (press) begin
                        seed_q      <= (fcnt_q == 16'h0000) ? 16'h0001 : fcnt_q;
                        score_q     <= '0;
                        seed_load_q <= 1'b1;
                        enable_q    <= 1'b1;
                        state_q     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (tick_q) begin
                        if (crash) begin
                            enable_q   <= 1'b0;
                            hold_cnt_q <= '0;
                            state_q    <= S_OVER;
                        end else begin
                            score_q <= bcd_inc(score_q);
                        end
                    end
                end
                S_OVER: begin
                    if (tick_q) begin
                        hold_cnt_q <= hold_cnt_d;
                        if (hold_cnt_d == HOLD_LAST) state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    enable_q <= 1'b0;
                end
            endcase
        end
    end

    assign tick      = tick_q;
    assign enable    = enable_q;
    assign seed_load = seed_load_q;
    assign seed      = seed_q;
    assign btn_held  = btn_held_q;
    assign score     = score_q;
    assign state     = state_q;

endmodule

// File: tb/tb_cave_game_ctrl.sv
// Directed bench for cave_game_ctrl with TICK_DIV=8, DB_CYCLES=4, HOLD_TICKS=3.
module tb_cave_game_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        btn = 1'b0;
    logic        crash = 1'b0;
    logic        tick, enable, seed_load, btn_held;
    logic [15:0] seed, score, hscore;
    logic [1:0]  state;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [15:0] m_fcnt = 16'h0;

    cave_game_ctrl #(.TICK_DIV(8), .DB_CYCLES(4), .HOLD_TICKS(3)) dut (
        .clk(clk), .reset(reset), .btn(btn), .crash(crash),
        .tick(tick), .enable(enable), .seed_load(seed_load), .seed(seed),
        .btn_held(btn_held), .score(score), .hscore(hscore), .state(state)
    );

    always #5 clk = ~clk;

    // Reference copy of the free-running cycle counter, used to aim the start press.
    always @(posedge clk) begin
        if (reset) m_fcnt <= 16'h0;
        else       m_fcnt <= m_fcnt + 16'd1;
    end

    function automatic logic [15:0] hs_exp(input logic [15:0] v);
`ifdef CAVE_HISCORE_EN
        return v;
`else
        return 16'h0000 & v;
`endif
    endfunction

    // Advance until n ticks have been seen; ends on the negedge after the last tick's edge.
    task automatic wait_ticks(input int n);
        int seen = 0;
        int budget = n * 8 + 20;
        while (seen < n && budget > 0) begin
            if (tick) seen++;
            @(negedge clk);
            budget--;
        end
        vec_cnt++;
        if (seen !== n) begin
            err_cnt++;
            $display("FAIL tick_wait: saw %0d ticks, required %0d", seen, n);
        end
    endtask

    task automatic start_game();
        int budget = 20;
        btn = 1'b1;
        while (!seed_load && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        vec_cnt++;
        if ({seed_load, enable, state} !== 4'b1101) begin
            err_cnt++;
            $display("FAIL start: seed_load/enable/state=%b, required 1101", {seed_load, enable, state});
        end
    endtask

    task automatic crash_game(input logic [15:0] exp_score, input logic [15:0] exp_hs);
        crash = 1'b1;
        wait_ticks(1);
        crash = 1'b0;
        vec_cnt++;
        if ({state, enable, score, hscore} !== {2'b10, 1'b0, exp_score, exp_hs}) begin
            err_cnt++;
            $display("FAIL crash: state=%b enable=%b score=%h hscore=%h, required 10 0 %h %h",
                     state, enable, score, hscore, exp_score, exp_hs);
        end
    endtask

    task automatic test_reset(input string nm);
        reset = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if ({tick, enable, seed_load, seed, btn_held, score, hscore, state} !== 52'h0) begin
            err_cnt++;
            $display("FAIL %s: tick=%b en=%b sl=%b seed=%h held=%b score=%h hs=%h state=%b, required all 0",
                     nm, tick, enable, seed_load, seed, btn_held, score, hscore, state);
        end
        reset = 1'b0;
    endtask

    task automatic test_tick();
        int first = 0;
        int gap = 0;
        for (int i = 1; i <= 12 && first == 0; i++) begin
            @(negedge clk);
            if (tick) first = i;
        end
        vec_cnt++;
        if (first !== 7) begin
            err_cnt++;
            $display("FAIL tick_first: first tick after %0d cycles, required 7", first);
        end
        for (int i = 1; i <= 12 && gap == 0; i++) begin
            @(negedge clk);
            if (tick) gap = i;
        end
        vec_cnt++;
        if (gap !== 8) begin
            err_cnt++;
            $display("FAIL tick_period: gap %0d, required 8", gap);
        end
    endtask

    task automatic test_glitch();
        logic any_hi = 1'b0;
        btn = 1'b1;
        repeat (3) @(negedge clk);
        btn = 1'b0;
        repeat (12) begin
            @(negedge clk);
            any_hi = any_hi | btn_held | seed_load | (state != 2'b00);
        end
        vec_cnt++;
        if (any_hi !== 1'b0) begin
            err_cnt++;
            $display("FAIL glitch: activity=%b, required 0", any_hi);
        end
    endtask

    task automatic test_start_seed();
        int budget = 70000;
        int n = 0;
        while (m_fcnt != 16'h122E && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        btn = 1'b1;
        for (int i = 0; i <= 6; i++) begin
            @(negedge clk);
            if (i == 4) begin
                vec_cnt++;
                if ({btn_held, seed_load, state} !== 4'b0000) begin
                    err_cnt++;
                    $display("FAIL db_early: held/sl/state=%b, required 0000", {btn_held, seed_load, state});
                end
            end
            if (i == 5) begin
                vec_cnt++;
                if ({btn_held, seed_load, state} !== 4'b1000) begin
                    err_cnt++;
                    $display("FAIL db_edge: held/sl/state=%b, required 1000", {btn_held, seed_load, state});
                end
            end
        end
        vec_cnt++;
        if ({seed_load, enable, state, seed} !== {1'b1, 1'b1, 2'b01, 16'h1234}) begin
            err_cnt++;
            $display("FAIL seed: sl=%b en=%b state=%b seed=%h, required 1 1 01 1234",
                     seed_load, enable, state, seed);
        end
        if (tick) n = 1;
        @(negedge clk);
        vec_cnt++;
        if (seed_load !== 1'b0) begin
            err_cnt++;
            $display("FAIL seed_pulse: seed_load=%b, required 0", seed_load);
        end
        wait_ticks(12 - n);
        btn = 1'b0;
        vec_cnt++;
        if (score !== 16'h0012) begin
            err_cnt++;
            $display("FAIL score12: score=%h, required 0012", score);
        end
    endtask

    task automatic test_bcd();
        wait_ticks(987);
        vec_cnt++;
        if (score !== 16'h0999) begin
            err_cnt++;
            $display("FAIL score999: score=%h, required 0999", score);
        end
        wait_ticks(1);
        vec_cnt++;
        if (score !== 16'h1000) begin
            err_cnt++;
            $display("FAIL carry: score=%h, required 1000", score);
        end
        dut.score_q = 16'h9998;
        wait_ticks(1);
        vec_cnt++;
        if (score !== 16'h9999) begin
            err_cnt++;
            $display("FAIL to9999: score=%h, required 9999", score);
        end
        wait_ticks(1);
        vec_cnt++;
        if (score !== 16'h9999) begin
            err_cnt++;
            $display("FAIL saturate: score=%h, required 9999", score);
        end
    endtask

    task automatic test_reset_run();
        start_game();
        btn = 1'b0;
        wait_ticks(5);
        vec_cnt++;
        if (score !== 16'h0005) begin
            err_cnt++;
            $display("FAIL score5: score=%h, required 0005", score);
        end
        test_reset("reset_run");
    endtask

    task automatic test_crash_hold();
        logic sl_seen = 1'b0;
        start_game();
        wait_ticks(42);
        vec_cnt++;
        if (score !== 16'h0042) begin
            err_cnt++;
            $display("FAIL score42: score=%h, required 0042", score);
        end
        crash_game(16'h0042, hs_exp(16'h0042));
        wait_ticks(2);
        vec_cnt++;
        if (state !== 2'b10) begin
            err_cnt++;
            $display("FAIL hold2: state=%b, required 10", state);
        end
        wait_ticks(1);
        vec_cnt++;
        if (state !== 2'b00) begin
            err_cnt++;
            $display("FAIL hold3: state=%b, required 00", state);
        end
        repeat (20) begin
            @(negedge clk);
            sl_seen = sl_seen | seed_load;
        end
        vec_cnt++;
        if ({sl_seen, state, score} !== {1'b0, 2'b00, 16'h0042}) begin
            err_cnt++;
            $display("FAIL held_no_start: sl=%b state=%b score=%h, required 0 00 0042",
                     sl_seen, state, score);
        end
        btn = 1'b0;
        repeat (10) @(negedge clk);
        vec_cnt++;
        if ({btn_held, state} !== 3'b000) begin
            err_cnt++;
            $display("FAIL release: held/state=%b, required 000", {btn_held, state});
        end
    endtask

    task automatic test_hiscore();
        start_game();
        btn = 1'b0;
        wait_ticks(42);
        crash_game(16'h0042, hs_exp(16'h0042));
        wait_ticks(3);
        start_game();
        btn = 1'b0;
        wait_ticks(30);
        crash_game(16'h0030, hs_exp(16'h0042));
        wait_ticks(3);
        vec_cnt++;
        if ({state, score} !== {2'b00, 16'h0030}) begin
            err_cnt++;
            $display("FAIL idle_keep: state=%b score=%h, required 00 0030", state, score);
        end
        start_game();
        btn = 1'b0;
        wait_ticks(43);
        crash_game(16'h0043, hs_exp(16'h0043));
    endtask

    initial begin
        @(negedge clk);
        test_reset("reset_init");
        test_tick();
        test_glitch();
        test_start_seed();
        test_bcd();
        test_reset("reset_sat");
        test_reset_run();
        test_crash_hold();
        test_hiscore();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
